// File: rtl/ghost_mover.sv
// Ghost tile mover: house release, door exit, roaming with tunnel wrap and respawn.
// Position and stepPulse update on the due edge itself; enable low freezes everything.
module ghost_mover #(
  parameter int MAP_W          = 28,
  parameter int MAP_H          = 31,
  parameter int POS_W          = 5,
  parameter int TICKS_PER_STEP = 8,
  parameter int RELEASE_DELAY  = 64,
  parameter int START_X        = 13,
  parameter int START_Y        = 14,
  parameter int EXIT_Y         = 11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             respawn,
  input  logic             frightened,
  input  logic [1:0]       dirToMove,
  input  logic             canMoveU,
  input  logic             canMoveR,
  input  logic             canMoveD,
  input  logic             canMoveL,
  output logic [POS_W-1:0] ghostPosX,
  output logic [POS_W-1:0] ghostPosY,
  output logic [1:0]       curDir,
  output logic             stepPulse,
  output logic             roaming
);

  localparam int TICK_W = $clog2(2*TICKS_PER_STEP+1);
  localparam int REL_W  = $clog2(RELEASE_DELAY+1);

  localparam logic [POS_W-1:0] X_START = POS_W'(START_X);
  localparam logic [POS_W-1:0] Y_START = POS_W'(START_Y);
  localparam logic [POS_W-1:0] Y_EXIT  = POS_W'(EXIT_Y);
  localparam logic [POS_W-1:0] X_LAST  = POS_W'(MAP_W-1);
  localparam logic [POS_W-1:0] Y_LAST  = POS_W'(MAP_H-1);
  localparam logic [1:0] DIR_U = 2'd0, DIR_R = 2'd1, DIR_D = 2'd2, DIR_L = 2'd3;

  typedef enum logic [1:0] {HOUSE, EXIT, ROAM} state_t;

  state_t             state, state_nxt;
  logic [POS_W-1:0]   pos_x, pos_y, pos_x_nxt, pos_y_nxt;
  logic [1:0]         dir_q, dir_nxt;
  logic               step_q, step_nxt;
  logic [TICK_W-1:0]  tick, tick_nxt, period_m1;
  logic [REL_W-1:0]   rel, rel_nxt;
  logic               due;
  logic [3:0]         can_vec;
  logic [1:0]         mv_dir;
  logic               mv_ok;
  logic [POS_W-1:0]   tgt_x, tgt_y;

  assign period_m1 = frightened ? TICK_W'(2*TICKS_PER_STEP-1) : TICK_W'(TICKS_PER_STEP-1);
  assign due       = (tick >= period_m1);

  // Vertical maze edges count as walls so the fallback to curDir still applies.
  assign can_vec = {canMoveL, canMoveD & (pos_y != Y_LAST), canMoveR, canMoveU & (pos_y != '0)};
  assign mv_dir  = can_vec[dirToMove] ? dirToMove : dir_q;
  assign mv_ok   = can_vec[dirToMove] | can_vec[dir_q];

  always_comb begin
    tgt_x = pos_x;
    tgt_y = pos_y;
    case (mv_dir)
      DIR_U:   tgt_y = pos_y - POS_W'(1);
      DIR_R:   tgt_x = (pos_x == X_LAST) ? '0 : pos_x + POS_W'(1);
      DIR_D:   tgt_y = pos_y + POS_W'(1);
      default: tgt_x = (pos_x == '0) ? X_LAST : pos_x - POS_W'(1);
    endcase
  end

  always_comb begin
    state_nxt = state;
    pos_x_nxt = pos_x;
    pos_y_nxt = pos_y;
    dir_nxt   = dir_q;
    step_nxt  = 1'b0;
    tick_nxt  = tick;
    rel_nxt   = rel;
    if (respawn) begin
      state_nxt = HOUSE;
      pos_x_nxt = X_START;
      pos_y_nxt = Y_START;
      dir_nxt   = DIR_U;
      tick_nxt  = '0;
      rel_nxt   = '0;
    end else if (enable) begin
      case (state)
        HOUSE: begin
          tick_nxt = '0;
          if (rel == REL_W'(RELEASE_DELAY-1)) begin
            state_nxt = EXIT;
            rel_nxt   = '0;
          end else begin
            rel_nxt = rel + REL_W'(1);
          end
        end
        EXIT: begin
          tick_nxt = due ? '0 : tick + TICK_W'(1);
          if (due) begin
            pos_y_nxt = pos_y - POS_W'(1);
            dir_nxt   = DIR_U;
            step_nxt  = 1'b1;
            if (pos_y - POS_W'(1) == Y_EXIT) begin
              state_nxt = ROAM;
              dir_nxt   = DIR_L;
            end
          end
        end
        default: begin
          tick_nxt = due ? '0 : tick + TICK_W'(1);
          if (due && mv_ok) begin
            pos_x_nxt = tgt_x;
            pos_y_nxt = tgt_y;
            dir_nxt   = mv_dir;
            step_nxt  = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= HOUSE;
      pos_x  <= X_START;
      pos_y  <= Y_START;
      dir_q  <= DIR_U;
      step_q <= 1'b0;
      tick   <= '0;
      rel    <= '0;
    end else begin
      state  <= state_nxt;
      pos_x  <= pos_x_nxt;
      pos_y  <= pos_y_nxt;
      dir_q  <= dir_nxt;
      step_q <= step_nxt;
      tick   <= tick_nxt;
      rel    <= rel_nxt;
    end
  end

  assign ghostPosX = pos_x;
  assign ghostPosY = pos_y;
  assign curDir    = dir_q;
  assign stepPulse = step_q;
  assign roaming   = (state == ROAM);

endmodule
